dcache_line_mem_responder: RTL and testbench

- Memory-side responder for the data cache's line-level request interface (line address, read/write strobes, 256-bit write line with byte enables).
- Converts each line request into a fixed-length 4-beat burst on a 64-bit main-memory interface.
- Returns a full line to the cache with a one-cycle completion pulse.
- Sits between the data cache request registers and the memory arbiter.

---
 rtl/dcache_line_mem_responder.sv | 85 ++++++++
 tb/tb_dcache_line_mem_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_line_mem_responder.sv
// dcache_line_mem_responder: turns cache line fill/write-back requests into fixed 4-beat
// 64-bit memory bursts and returns a full line with a one-cycle completion pulse.
module dcache_line_mem_responder #(
  parameter int ADDR_WIDTH          = 32,
  parameter int CACHELINE_BIT_WIDTH = 256,
  parameter int BYTES_IN_CACHELINE  = 32,
  parameter int BURST_WIDTH         = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [ADDR_WIDTH-1:0]            line_addr,
  input  logic                             line_read,
  input  logic                             line_write,
  input  logic [CACHELINE_BIT_WIDTH-1:0]   line_wdata,
  input  logic [BYTES_IN_CACHELINE-1:0]    line_wben,
  output logic [CACHELINE_BIT_WIDTH-1:0]   line_rdata,
  output logic                             line_resp,
  output logic [ADDR_WIDTH-1:0]            burst_addr,
  output logic                             burst_read,
  output logic                             burst_write,
  output logic [BURST_WIDTH-1:0]           burst_wdata,
  output logic [BURST_WIDTH/8-1:0]         burst_wben,
  input  logic [BURST_WIDTH-1:0]           burst_rdata,
  input  logic                             burst_resp
);
  localparam int BEATS = CACHELINE_BIT_WIDTH / BURST_WIDTH;
  localparam int CW    = $clog2(BEATS);
  localparam int BB    = BURST_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] cnt, nk;
  logic [CACHELINE_BIT_WIDTH-1:0] wdata_q;
  logic [BYTES_IN_CACHELINE-1:0] wben_q;
  logic [ADDR_WIDTH-1:0] aligned;
  logic last;
  assign aligned = line_addr & ~ADDR_WIDTH'(BYTES_IN_CACHELINE - 1);
  assign last    = burst_resp && cnt == CW'(BEATS - 1);
  assign nk      = cnt + CW'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= next;
  // write wins over read when both are requested in the same cycle
  always_comb
    next = state == IDLE ? (line_write ? WRITE : line_read ? READ : IDLE) :
           state == DONE ? IDLE : last ? DONE : state;
  // outputs are registered; the next write beat is staged on the edge that accepts the current one
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt         <= '0;
      wdata_q     <= '0;
      wben_q      <= '0;
      line_rdata  <= '0;
      line_resp   <= 1'b0;
      burst_addr  <= '0;
      burst_read  <= 1'b0;
      burst_write <= 1'b0;
      burst_wdata <= '0;
      burst_wben  <= '0;
    end else
      case (state)
        IDLE: begin
          if (line_write || line_read) burst_addr <= aligned;
          wdata_q     <= line_wdata;
          wben_q      <= line_wben;
          burst_write <= line_write;
          burst_read  <= line_read && !line_write;
          burst_wdata <= line_write ? line_wdata[BURST_WIDTH-1:0] : '0;
          burst_wben  <= line_write ? line_wben[BB-1:0] : '0;
        end
        READ: if (burst_resp) begin
          line_rdata[BURST_WIDTH*cnt +: BURST_WIDTH] <= burst_rdata;
          cnt        <= last ? '0 : nk;
          burst_read <= !last;
          line_resp  <= last;
        end
        WRITE: if (burst_resp) begin
          cnt         <= last ? '0 : nk;
          burst_write <= !last;
          line_resp   <= last;
          burst_wdata <= last ? '0 : wdata_q[BURST_WIDTH*nk +: BURST_WIDTH];
          burst_wben  <= last ? '0 : wben_q[BB*nk +: BB];
        end
        DONE: line_resp <= 1'b0;
      endcase
endmodule

// File: tb/tb_dcache_line_mem_responder.sv
// tb_dcache_line_mem_responder: directed scenarios for the line-to-burst responder
// with hand-computed beat sequences and line images.
module tb_dcache_line_mem_responder;
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  line_addr;
  logic         line_read, line_write;
  logic [255:0] line_wdata;
  logic [31:0]  line_wben;
  logic [255:0] line_rdata;
  logic         line_resp;
  logic [31:0]  burst_addr;
  logic         burst_read, burst_write;
  logic [63:0]  burst_wdata;
  logic [7:0]   burst_wben;
  logic [63:0]  burst_rdata;
  logic         burst_resp;
  int checks = 0;
  int errors = 0;
  logic [255:0] exp_line;
  dcache_line_mem_responder dut (
    .clk(clk), .rst(rst),
    .line_addr(line_addr), .line_read(line_read), .line_write(line_write),
    .line_wdata(line_wdata), .line_wben(line_wben),
    .line_rdata(line_rdata), .line_resp(line_resp),
    .burst_addr(burst_addr), .burst_read(burst_read), .burst_write(burst_write),
    .burst_wdata(burst_wdata), .burst_wben(burst_wben),
    .burst_rdata(burst_rdata), .burst_resp(burst_resp)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clear_inputs;
    line_addr = '0; line_read = 0; line_write = 0; line_wdata = '0; line_wben = '0;
    burst_rdata = '0; burst_resp = 0;
  endtask
  task automatic do_read(input logic [31:0] a, input logic [255:0] l);
    line_read = 1; line_addr = a;
    tick;
    line_read = 0;
    for (int k = 0; k < 4; k++) begin
      burst_resp = 1; burst_rdata = l[64*k +: 64];
      tick;
    end
    burst_resp = 0;
    tick;
  endtask
  task automatic test_reset;
    clear_inputs;
    rst = 0;
    #12;
    checks++;
    if ({line_rdata, line_resp, burst_addr, burst_read, burst_write, burst_wdata, burst_wben} !== '0)
      begin errors++; $display("FAIL reset_state: outputs not all zero, line_rdata=%h burst_addr=%h", line_rdata, burst_addr); end
    @(negedge clk) rst = 1;
    tick;
    line_read = 1; line_addr = 32'h0000_0300;
    tick;
    line_read = 0;
    checks++;
    if (burst_read !== 1'b1 || burst_addr !== 32'h0000_0300)
      begin errors++; $display("FAIL reset_pre_read: burst_read=%b burst_addr=%h want 1/00000300", burst_read, burst_addr); end
    for (int k = 0; k < 2; k++) begin
      burst_resp = 1; burst_rdata = 64'h0BAD_0000_0000_0000 + 64'(k);
      tick;
    end
    #2 rst = 0;
    #2;
    checks++;
    if ({line_rdata, line_resp, burst_addr, burst_read, burst_write, burst_wdata, burst_wben} !== '0)
      begin errors++; $display("FAIL reset_mid_read: outputs not zero, burst_read=%b line_rdata=%h", burst_read, line_rdata); end
    burst_resp = 0;
    @(negedge clk) rst = 1;
    tick;
    exp_line = {64'h4040_4040_0000_0004, 64'h3030_3030_0000_0003, 64'h2020_2020_0000_0002, 64'h1010_1010_0000_0001};
    line_read = 1; line_addr = 32'h0000_0100;
    tick;
    line_read = 0;
    checks++;
    if (burst_read !== 1'b1 || burst_addr !== 32'h0000_0100)
      begin errors++; $display("FAIL reset_new_read: burst_read=%b burst_addr=%h want 1/00000100", burst_read, burst_addr); end
    for (int k = 0; k < 4; k++) begin
      burst_resp = 1; burst_rdata = exp_line[64*k +: 64];
      tick;
    end
    burst_resp = 0;
    checks++;
    if (line_resp !== 1'b1 || line_rdata !== exp_line)
      begin errors++; $display("FAIL reset_new_line: line_resp=%b line_rdata=%h want 1/%h", line_resp, line_rdata, exp_line); end
    tick;
  endtask
  task automatic test_read_fill;
    exp_line = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
    line_read = 1; line_addr = 32'h0000_1234;
    tick;
    line_read = 0;
    checks++;
    if (burst_read !== 1'b1 || burst_write !== 1'b0 || burst_addr !== 32'h0000_1220)
      begin errors++; $display("FAIL fill_start: read=%b write=%b addr=%h want 1/0/00001220", burst_read, burst_write, burst_addr); end
    for (int k = 0; k < 4; k++) begin
      burst_resp = 1; burst_rdata = exp_line[64*k +: 64];
      tick;
      checks++;
      if (k < 3 ? (line_resp !== 1'b0 || burst_read !== 1'b1) : (line_resp !== 1'b1 || burst_read !== 1'b0))
        begin errors++; $display("FAIL fill_beat%0d: line_resp=%b burst_read=%b", k, line_resp, burst_read); end
    end
    burst_resp = 0;
    checks++;
    if (line_rdata !== exp_line)
      begin errors++; $display("FAIL fill_line: got %h want %h", line_rdata, exp_line); end
    tick;
    checks++;
    if (line_resp !== 1'b0)
      begin errors++; $display("FAIL fill_resp_pulse: line_resp=%b want 0", line_resp); end
  endtask
  task automatic test_write_back;
    logic [63:0] wd [4];
    logic [7:0]  be [4];
    wd = '{64'hAAAA_0000_1111_0000, 64'hBBBB_2222_0000_3333, 64'hCCCC_4444_5555_6666, 64'hDDDD_7777_8888_9999};
    be = '{8'hFF, 8'h00, 8'hF0, 8'hF0};
    line_write = 1; line_addr = 32'h0000_5678;
    line_wdata = {wd[3], wd[2], wd[1], wd[0]}; line_wben = 32'hF0F0_00FF;
    tick;
    line_write = 0; line_wdata = '0; line_wben = '0;
    checks++;
    if (burst_write !== 1'b1 || burst_read !== 1'b0 || burst_addr !== 32'h0000_5660)
      begin errors++; $display("FAIL wb_start: write=%b read=%b addr=%h want 1/0/00005660", burst_write, burst_read, burst_addr); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (burst_wdata !== wd[k] || burst_wben !== be[k] || line_resp !== 1'b0)
        begin errors++; $display("FAIL wb_beat%0d: wdata=%h wben=%h resp=%b want %h/%h/0", k, burst_wdata, burst_wben, line_resp, wd[k], be[k]); end
      burst_resp = 1;
      tick;
    end
    burst_resp = 0;
    checks++;
    if (line_resp !== 1'b1 || burst_write !== 1'b0 || line_rdata !== exp_line)
      begin errors++; $display("FAIL wb_done: resp=%b write=%b line_rdata=%h want 1/0/%h", line_resp, burst_write, line_rdata, exp_line); end
    tick;
  endtask
  task automatic test_stalled_read;
    int pat [7];
    int j;
    pat = '{1, 0, 0, 1, 1, 0, 1};
    j = 0;
    exp_line = {64'h8888_0000_0000_0008, 64'h7777_0000_0000_0007, 64'h6666_0000_0000_0006, 64'h5555_0000_0000_0005};
    line_read = 1; line_addr = 32'h2000_0040;
    tick;
    line_read = 0;
    for (int i = 0; i < 7; i++) begin
      burst_resp = pat[i][0];
      burst_rdata = pat[i] != 0 ? exp_line[64*j +: 64] : 64'hDEAD_BEEF_DEAD_BEEF;
      tick;
      if (pat[i] != 0) j++;
      checks++;
      if (i < 6 ? (line_resp !== 1'b0 || burst_read !== 1'b1) : (line_resp !== 1'b1 || burst_read !== 1'b0))
        begin errors++; $display("FAIL stall_cycle%0d: line_resp=%b burst_read=%b", i, line_resp, burst_read); end
    end
    burst_resp = 0;
    checks++;
    if (line_rdata !== exp_line || burst_addr !== 32'h2000_0040)
      begin errors++; $display("FAIL stall_line: line_rdata=%h addr=%h want %h/20000040", line_rdata, burst_addr, exp_line); end
    tick;
    checks++;
    if (line_resp !== 1'b0)
      begin errors++; $display("FAIL stall_resp_pulse: line_resp=%b want 0", line_resp); end
  endtask
  task automatic test_simultaneous;
    logic [255:0] prev;
    prev = exp_line;
    line_read = 1; line_write = 1; line_addr = 32'h0000_0047;
    line_wdata = {4{64'h0123_4567_89AB_CDEF}}; line_wben = '1;
    tick;
    line_read = 0; line_write = 0;
    checks++;
    if (burst_write !== 1'b1 || burst_read !== 1'b0 || burst_addr !== 32'h0000_0040)
      begin errors++; $display("FAIL both_start: write=%b read=%b addr=%h want 1/0/00000040", burst_write, burst_read, burst_addr); end
    for (int k = 0; k < 4; k++) begin
      burst_resp = 1;
      tick;
    end
    burst_resp = 0;
    checks++;
    if (line_resp !== 1'b1 || line_rdata !== prev)
      begin errors++; $display("FAIL both_wb_done: resp=%b line_rdata=%h", line_resp, line_rdata); end
    tick;
    checks++;
    if (burst_read !== 1'b0 || burst_write !== 1'b0)
      begin errors++; $display("FAIL both_no_queue: read=%b write=%b want 0/0", burst_read, burst_write); end
    exp_line = {64'hD4, 64'hC3, 64'hB2, 64'hA1};
    line_read = 1; line_addr = 32'h0000_0080;
    tick;
    line_read = 0;
    checks++;
    if (burst_read !== 1'b1 || burst_addr !== 32'h0000_0080)
      begin errors++; $display("FAIL both_reread: read=%b addr=%h want 1/00000080", burst_read, burst_addr); end
    for (int k = 0; k < 4; k++) begin
      burst_resp = 1; burst_rdata = exp_line[64*k +: 64];
      tick;
    end
    burst_resp = 0;
    checks++;
    if (line_resp !== 1'b1 || line_rdata !== exp_line)
      begin errors++; $display("FAIL both_reread_line: resp=%b got %h want %h", line_resp, line_rdata, exp_line); end
    tick;
  endtask
  task automatic test_spurious;
    burst_resp = 1; burst_rdata = 64'hFFFF_EEEE_DDDD_CCCC;
    repeat (3) tick;
    burst_resp = 0;
    checks++;
    if (line_rdata !== exp_line || burst_read !== 1'b0 || burst_write !== 1'b0 || line_resp !== 1'b0)
      begin errors++; $display("FAIL spur_idle: line_rdata=%h read=%b write=%b resp=%b", line_rdata, burst_read, burst_write, line_resp); end
    exp_line = {64'h0D0D, 64'h0C0C, 64'h0B0B, 64'h0A0A};
    line_read = 1; line_addr = 32'h0000_0400;
    tick;
    line_read = 0;
    for (int k = 0; k < 4; k++) begin
      burst_resp = 1; burst_rdata = exp_line[64*k +: 64];
      tick;
    end
    burst_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
    tick;
    checks++;
    if (line_resp !== 1'b0 || line_rdata !== exp_line || burst_read !== 1'b0)
      begin errors++; $display("FAIL spur_done: resp=%b read=%b got %h want %h", line_resp, burst_read, line_rdata, exp_line); end
    tick;
    burst_resp = 0;
    checks++;
    if (line_rdata !== exp_line)
      begin errors++; $display("FAIL spur_after: got %h want %h", line_rdata, exp_line); end
    exp_line = {64'h3, 64'h2, 64'h1, 64'h0F00_0000_0000_0000};
    do_read(32'h0000_0800, exp_line);
    checks++;
    if (line_rdata !== exp_line)
      begin errors++; $display("FAIL spur_counter: got %h want %h", line_rdata, exp_line); end
  endtask
  initial begin
    test_reset;
    test_read_fill;
    test_write_back;
    test_stalled_read;
    test_simultaneous;
    test_spurious;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
